// File: rtl/conv3x3_mac_pipe.sv
// conv3x3_mac_pipe
//   Three-stage pipelined 3x3 convolution. It sits downstream of the 3x3
//   window generator and produces one filtered pixel per valid window.
//     S1: nine signed products  p_ij = $signed({1'b0, w_ij}) * k_ij
//     S2: three row partial sums
//     S3: total sum, round-half-up right shift, clamp to unsigned OUTW
//   Kernel coefficients and the shift amount can be reprogrammed at runtime.
//   Each write takes effect from the cycle after its strobe. The shift amount
//   travels down the pipe with its window, so a later shift write does not
//   change windows that are already in flight.
//
//   Optional build macro: CONV3X3_ABS_EN
//     When this macro is defined, S3 takes |sum| before the upper clamp
//     (edge-magnitude mode). When it is undefined, negative sums clamp to 0
//     and set out_sat.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   win_valid         window taps valid this cycle (no backpressure)
//   w00..w22          window taps, row-major, unsigned BITW
//   coef_we/addr/data coefficient write (addr 0..8 = k00..k22; 9..15 ignored)
//   shift_we/data     right-shift amount write (0..15)
//   out_valid         out_pix/out_sat carry a new sample
//   out_pix           filtered pixel (holds while out_valid=0)
//   out_sat           the sample was clamped (holds while out_valid=0)
//
// Handshake: win_valid qualifies the taps in the same cycle. The block always
// accepts a window, and out_valid is a one-cycle qualifier with no ready signal.
module conv3x3_mac_pipe #(
    parameter int BITW  = 8,
    parameter int COEFW = 8,
    parameter int OUTW  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    win_valid,
    input  logic [BITW-1:0]         w00,
    input  logic [BITW-1:0]         w01,
    input  logic [BITW-1:0]         w02,
    input  logic [BITW-1:0]         w10,
    input  logic [BITW-1:0]         w11,
    input  logic [BITW-1:0]         w12,
    input  logic [BITW-1:0]         w20,
    input  logic [BITW-1:0]         w21,
    input  logic [BITW-1:0]         w22,
    input  logic                    coef_we,
    input  logic [3:0]              coef_addr,
    input  logic signed [COEFW-1:0] coef_data,
    input  logic                    shift_we,
    input  logic [3:0]              shift_data,
    output logic                    out_valid,
    output logic [OUTW-1:0]         out_pix,
    output logic                    out_sat
);

    localparam int PW = BITW + 1 + COEFW;  // product width
    localparam int SW = PW + 2;            // row-sum width
    localparam int TW = PW + 4;            // total-sum width
    localparam int RW = TW + 1;            // extra bit so the rounding add cannot wrap
    localparam logic signed [RW-1:0] MAXV = RW'((1 << OUTW) - 1);

    logic [BITW-1:0] tap [0:8];
    assign tap[0] = w00;
    assign tap[1] = w01;
    assign tap[2] = w02;
    assign tap[3] = w10;
    assign tap[4] = w11;
    assign tap[5] = w12;
    assign tap[6] = w20;
    assign tap[7] = w21;
    assign tap[8] = w22;

    // Programmable state. The reset value is the identity kernel with no shift.
    logic signed [COEFW-1:0] k [0:8];
    logic [3:0]              shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                k[i] <= (i == 4) ? COEFW'(1) : '0;
            end
            shift_q <= '0;
        end else begin
            if (coef_we && (coef_addr < 4'd9)) begin
                k[coef_addr] <= coef_data;
            end
            if (shift_we) begin
                shift_q <= shift_data;
            end
        end
    end

    // Only the valid bits and the outputs are reset. Data registers may hold
    // stale values because the valid bits mask them.
    logic v1, v2;
    logic signed [PW-1:0] p [0:8];
    logic signed [SW-1:0] r [0:2];
    logic [3:0]           sh1, sh2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= win_valid;
            v2 <= v1;
        end
    end

    // S1 reads k and shift_q before any write on this same edge lands, so a
    // window presented together with a write uses the old settings.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            p[i] <= PW'($signed({1'b0, tap[i]})) * PW'(k[i]);
        end
        sh1 <= shift_q;
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            r[j] <= SW'(p[3*j]) + SW'(p[3*j+1]) + SW'(p[3*j+2]);
        end
        sh2 <= sh1;
    end

    // S3 combinational part: total sum, rounding shift, then clamp.
    logic signed [TW-1:0] total;
    logic signed [RW-1:0] rnd_c, rnd, shifted, mag;
    logic [OUTW-1:0]      clamp_pix;
    logic                 clamp_sat;

    always_comb begin
        total   = TW'(r[0]) + TW'(r[1]) + TW'(r[2]);
        rnd_c   = (sh2 != 4'd0) ? (RW'(1) <<< (sh2 - 4'd1)) : '0;
        rnd     = RW'(total) + rnd_c;
        shifted = rnd >>> sh2;
        mag     = shifted;
`ifdef CONV3X3_ABS_EN
        if (shifted < 0) begin
            mag = -shifted;
        end
`endif
        clamp_pix = mag[OUTW-1:0];
        clamp_sat = 1'b0;
        if (mag < 0) begin
            clamp_pix = '0;
            clamp_sat = 1'b1;
        end else if (mag > MAXV) begin
            clamp_pix = MAXV[OUTW-1:0];
            clamp_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                out_pix <= clamp_pix;
                out_sat <= clamp_sat;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_mac_pipe.sv
// Testbench for conv3x3_mac_pipe.
module tb_conv3x3_mac_pipe;

  localparam int BITW  = 8;
  localparam int COEFW = 8;
  localparam int OUTW  = 8;
  localparam int MAXP  = (1 << OUTW) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    win_valid = 1'b0;
  logic [BITW-1:0]         taps [9];
  logic                    coef_we = 1'b0;
  logic [3:0]              coef_addr = '0;
  logic signed [COEFW-1:0] coef_data = '0;
  logic                    shift_we = 1'b0;
  logic [3:0]              shift_data = '0;
  logic                    out_valid;
  logic [OUTW-1:0]         out_pix;
  logic                    out_sat;

  conv3x3_mac_pipe #(.BITW(BITW), .COEFW(COEFW), .OUTW(OUTW)) dut (
    .clk(clk), .rst(rst), .win_valid(win_valid),
    .w00(taps[0]), .w01(taps[1]), .w02(taps[2]),
    .w10(taps[3]), .w11(taps[4]), .w12(taps[5]),
    .w20(taps[6]), .w21(taps[7]), .w22(taps[8]),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .shift_we(shift_we), .shift_data(shift_data),
    .out_valid(out_valid), .out_pix(out_pix), .out_sat(out_sat)
  );

  // reference model state
  int          k_m [9];
  int          sh_m;
  logic [9:0]  exp_q [$];   // {valid, sat, pix} per output slot
  logic [7:0]  last_pix;
  logic        last_sat;
  logic [8:0]  obs_q [$];   // {sat, pix} of every observed valid output
  int          n_vec = 0;
  int          n_fail = 0;

  // Convolution computed directly from the arithmetic rules.
  function automatic logic [8:0] ref_out();
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) s += int'(taps[i]) * k_m[i];
    if (sh_m > 0) s += (1 << (sh_m - 1));
    s = s >>> sh_m;
`ifdef CONV3X3_ABS_EN
    if (s < 0) s = -s;
`endif
    if (s < 0) return {1'b1, 8'd0};
    if (s > MAXP) return {1'b1, 8'(MAXP)};
    return {1'b0, 8'(s)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) k_m[i] = (i == 4) ? 1 : 0;
    sh_m = 0;
    exp_q.delete();
    exp_q.push_back(10'd0);
    exp_q.push_back(10'd0);
    last_pix = '0;
    last_sat = 1'b0;
  endtask

  // One clock: the model records this cycle's window, applies the writes, and
  // then checks the DUT output slot for the window three cycles earlier.
  task automatic step(input string tag);
    logic [9:0] rec;
    rec = {win_valid, ref_out()};
    exp_q.push_back(rec);
    if (coef_we && coef_addr < 4'd9) k_m[coef_addr] = int'(coef_data);
    if (shift_we) sh_m = int'(shift_data);
    @(posedge clk); #1;
    rec = exp_q.pop_front();
    if (rec[9]) begin
      last_pix = rec[7:0];
      last_sat = rec[8];
    end
    n_vec++;
    if (out_valid !== rec[9]) begin
      n_fail++;
      $display("FAIL %s out_valid: got %b want %b", tag, out_valid, rec[9]);
    end
    n_vec++;
    if (out_pix !== last_pix) begin
      n_fail++;
      $display("FAIL %s out_pix: got %0d want %0d", tag, out_pix, last_pix);
    end
    n_vec++;
    if (out_sat !== last_sat) begin
      n_fail++;
      $display("FAIL %s out_sat: got %b want %b", tag, out_sat, last_sat);
    end
    if (out_valid === 1'b1) obs_q.push_back({out_sat, out_pix});
    win_valid = 1'b0;
    coef_we   = 1'b0;
    shift_we  = 1'b0;
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    win_valid = 1'b0;
    coef_we = 1'b0;
    shift_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    obs_q.delete();
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we = 1'b1;
    coef_addr = 4'(addr);
    coef_data = COEFW'(data);
    step("cfg");
  endtask

  task automatic write_shift(input int s);
    shift_we = 1'b1;
    shift_data = 4'(s);
    step("cfg");
  endtask

  task automatic set_taps(input int v);
    for (int i = 0; i < 9; i++) taps[i] = BITW'(v);
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic check_obs(input string tag, input int idx, input logic [8:0] want);
    n_vec++;
    if (obs_q.size() <= idx) begin
      n_fail++;
      $display("FAIL %s missing output %0d: got %0d outputs want > %0d", tag, idx, obs_q.size(), idx);
    end else if (obs_q[idx] !== want) begin
      n_fail++;
      $display("FAIL %s sample %0d {sat,pix}: got %0d/%0d want %0d/%0d", tag, idx,
               obs_q[idx][8], obs_q[idx][7:0], want[8], want[7:0]);
    end
  endtask

  // scenarios
  task automatic test_reset();
    set_taps(0);
    do_reset();
    n_vec++;
    if (out_valid !== 1'b0 || out_pix !== 8'd0 || out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got v=%b pix=%0d sat=%b want 0/0/0", out_valid, out_pix, out_sat);
    end
  endtask

  task automatic test_identity();
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      for (int t = 0; t < 9; t++) taps[t] = BITW'($urandom_range(0, 255));
      taps[4] = BITW'(i);
      win_valid = 1'b1;
      step("identity");
    end
    drain(3, "identity");
    n_vec++;
    if (obs_q.size() != 21) begin
      n_fail++;
      $display("FAIL identity count: got %0d want 21", obs_q.size());
    end
    for (int i = 0; i <= 20; i++) check_obs("identity", i, {1'b0, 8'(i)});
  endtask

  task automatic load_kernel(input int kv, input int k11, input int s);
    for (int i = 0; i < 9; i++) write_coef(i, (i == 4) ? k11 : kv);
    write_shift(s);
  endtask

  task automatic one_window(input string tag);
    obs_q.delete();
    win_valid = 1'b1;
    step(tag);
    drain(3, tag);
  endtask

  task automatic test_box_blur();
    load_kernel(1, 1, 3);
    set_taps(100);
    one_window("box");
    check_obs("box", 0, {1'b0, 8'd113});
  endtask

  task automatic test_laplacian();
    load_kernel(-1, 8, 0);
    set_taps(10);
    taps[4] = '0;
    one_window("laplacian");
`ifdef CONV3X3_ABS_EN
    check_obs("laplacian", 0, {1'b0, 8'd80});
`else
    check_obs("laplacian", 0, {1'b1, 8'd0});
`endif
  endtask

  task automatic test_saturation();
    load_kernel(127, 127, 0);
    set_taps(255);
    one_window("saturation");
    check_obs("saturation", 0, {1'b1, 8'd255});
  endtask

  task automatic test_coef_hazard();
    load_kernel(1, 1, 0);
    set_taps(1);
    obs_q.delete();
    win_valid = 1'b1;                // window A with a k00=5 write in the same cycle
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'sd5;
    step("hazard");
    win_valid = 1'b1; step("hazard");   // B
    win_valid = 1'b1; step("hazard");   // C
    win_valid = 1'b1;                // D, with an out-of-range write
    coef_we = 1'b1; coef_addr = 4'd12; coef_data = 8'sd7;
    step("hazard");
    win_valid = 1'b1; step("hazard");   // E
    drain(3, "hazard");
    check_obs("hazard_a", 0, {1'b0, 8'd9});
    check_obs("hazard_b", 1, {1'b0, 8'd13});
    check_obs("hazard_c", 2, {1'b0, 8'd13});
    check_obs("hazard_addr12", 4, {1'b0, 8'd13});
  endtask

  task automatic test_bubbles_and_reset();
    logic [4:0] pat;
    pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_taps(3);
      taps[4] = BITW'(50 + i);
      win_valid = pat[i];
      step("bubbles");
    end
    drain(3, "bubbles");
    check_obs("bubbles", 0, {1'b0, 8'd50});
    check_obs("bubbles", 1, {1'b0, 8'd52});
    check_obs("bubbles", 2, {1'b0, 8'd53});
    // Two windows in flight under a box kernel, then reset on the next cycle.
    load_kernel(1, 1, 0);
    set_taps(7);
    obs_q.delete();
    win_valid = 1'b1; step("midreset");
    win_valid = 1'b1; step("midreset");
    do_reset();
    drain(5, "midreset");
    n_vec++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset flushed: got %0d outputs want 0", obs_q.size());
    end
    set_taps(9);
    taps[4] = 8'd77;
    one_window("post_reset_identity");
    check_obs("post_reset_identity", 0, {1'b0, 8'd77});
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int t = 0; t < 9; t++) taps[t] = BITW'($urandom_range(0, 255));
      win_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        coef_we = 1'b1;
        coef_addr = 4'($urandom_range(0, 15));
        coef_data = COEFW'(int'($urandom_range(0, 40)) - 20);
      end
      if ($urandom_range(0, 7) == 0) begin
        shift_we = 1'b1;
        shift_data = 4'($urandom_range(0, 15));
      end
      step("random");
    end
    drain(3, "random");
  endtask

  initial begin
    set_taps(0);
    test_reset();
    test_identity();
    test_box_blur();
    test_laplacian();
    test_saturation();
    test_coef_hazard();
    test_bubbles_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
